// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment pattern constants, blank code and receiver FSM states shared with the display driver
package seg_pkg;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
endpackage

// File: rtl/seg_scan_receiver_if.sv
// seg_scan_receiver_if: scanned display lines plus decoded frame and error pulses
interface seg_scan_receiver_if #(parameter int DIGITS = 4);
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   dig_n;
  logic [4*DIGITS-1:0] digit_value;
  logic                frame_valid;
  logic                err_pattern;
  logic                err_select;
  logic                err_timeout;
  modport master (output seg_n, dig_n, input digit_value, frame_valid, err_pattern, err_select, err_timeout);
  modport slave  (input seg_n, dig_n, output digit_value, frame_valid, err_pattern, err_select, err_timeout);
endinterface

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: maps an active-high gfedcba pattern to its BCD code, blank, or invalid
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] code_o
);
  // table lookup against the shared pattern constants
  always_comb begin
    valid_o = 1'b1;
    code_o  = BLANK_CODE;
    case (seg_i)
      SEG_0:     code_o = 4'd0;
      SEG_1:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
      SEG_BLANK: code_o = BLANK_CODE;
      default:   valid_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg_scan_receiver.sv
// seg_scan_receiver: settles scanned digit slots, decodes them into a frame; SEG_SCAN_TIMEOUT_EN adds a frame timeout
module seg_scan_receiver
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT       = 262144
)(
  input logic clock,
  input logic reset,
  seg_scan_receiver_if.slave bus
);
  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || TIMEOUT < 2) begin : g_bad_param
    $error("seg_scan_receiver: STABLE_CYCLES and TIMEOUT must be at least 2");
  end

  logic [SW-1:0]       sync1_q, sync2_q, prev_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [DIGITS-1:0]   sel, seen_q, seen_d, seen_set;
  logic [6:0]          pat;
  logic [3:0]          pat_code;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow_q, shadow_d, digit_q;
  logic changed, eval, sel_idle, sel_multi, sel_one, pat_valid, wr, complete, timeout_hit;
  logic fv_q, ep_q, es_q, et_q;

  assign sel       = ~sync2_q[SW-1:7];
  assign pat       = ~sync2_q[6:0];
  assign changed   = sync2_q != prev_q;
  assign sel_idle  = sel == '0;
  assign sel_multi = (sel & (sel - 1'b1)) != '0;
  assign sel_one   = !sel_idle && !sel_multi;
  assign cnt_d     = changed ? '0 : (cnt_q == CMAX ? cnt_q : cnt_q + 1'b1);

  seg_pattern_decode u_decode (.seg_i(pat), .valid_o(pat_valid), .code_o(pat_code));

  // index of the single active select line
  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) if (sel[i]) idx = IW'(i);
  end

  // two-flop synchronizer, previous-sample register and stability counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {bus.dig_n, bus.seg_n};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a settled slot is evaluated once, then held until the sample moves
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = changed ? SETTLE : IDLE;
      SETTLE:  state_d = eval ? (sel_idle ? IDLE : HELD) : SETTLE;
      HELD:    state_d = changed ? (sel_idle ? IDLE : SETTLE) : HELD;
      default: state_d = IDLE;
    endcase
  end

  // FSM output: single evaluation strobe when the counter saturates on an unchanged sample
  always_comb begin
    eval = state_q == SETTLE && !changed && cnt_q == CMAX;
  end

  // capture into the shadow frame and detect completion
  always_comb begin
    wr       = eval && sel_one && pat_valid;
    seen_set = seen_q | (wr ? sel : '0);
    complete = wr && &seen_set;
    shadow_d = shadow_q;
    if (wr) shadow_d[idx*4 +: 4] = pat_code;
    seen_d   = (complete || timeout_hit) ? '0 : seen_set;
  end

`ifdef SEG_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] to_q;
  assign timeout_hit = to_q == TW'(TIMEOUT - 1);
  // frame timeout counter, restarted by each completed frame or by its own expiry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) to_q <= '0;
    else        to_q <= (complete || timeout_hit) ? '0 : to_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // frame registers and registered one-cycle pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seen_q   <= '0;
      shadow_q <= '0;
      digit_q  <= '0;
      fv_q     <= 1'b0;
      ep_q     <= 1'b0;
      es_q     <= 1'b0;
      et_q     <= 1'b0;
    end else begin
      seen_q   <= seen_d;
      shadow_q <= shadow_d;
      if (complete) digit_q <= shadow_d;
      fv_q     <= complete;
      ep_q     <= eval && sel_one && !pat_valid;
      es_q     <= eval && sel_multi;
      et_q     <= timeout_hit;
    end
  end

  assign bus.digit_value = digit_q;
  assign bus.frame_valid = fv_q;
  assign bus.err_pattern = ep_q;
  assign bus.err_select  = es_q;
  assign bus.err_timeout = et_q;
endmodule

// File: tb/tb_seg_scan_receiver.sv
// tb_seg_scan_receiver: scoreboard bench; expected pulses are queued at stimulus time and matched on each DUT pulse
module tb_seg_scan_receiver;
  import seg_pkg::*;
  localparam int DIGITS = 4;
`ifdef SEG_SCAN_TIMEOUT_EN
  localparam int TO   = 1000;
  localparam int LONG = 40;
`else
  localparam int TO   = 262144;
  localparam int LONG = 8192;
`endif
  localparam int LAT = 19;

  typedef struct {int kind; logic [15:0] val; int at;} ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_frame = 0;
  ev_t  q[$];

  seg_scan_receiver_if #(.DIGITS(DIGITS)) bus ();
  seg_scan_receiver #(.DIGITS(DIGITS), .STABLE_CYCLES(16), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] val, input int at);
    q.push_back('{kind: kind, val: val, at: at});
  endtask

  task automatic slot(input int d, input logic [6:0] pat, input int hold);
    bus.dig_n = ~4'(1 << d);
    bus.seg_n = ~pat;
    repeat (hold) @(posedge clock);
    #1;
  endtask

  task automatic gap(input int n);
    bus.dig_n = '1;
    bus.seg_n = '1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic scan(input int d, input logic [6:0] pat, input int hold);
    slot(d, pat, hold);
    gap(30);
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    @(posedge clock);
    while (q.size() != 0 && n < bound) begin
      @(posedge clock);
      n++;
    end
    #1;
    check(tag, q.size(), 0);
    q.delete();
  endtask

  // match every output pulse against the oldest queued expectation
  always @(negedge clock) begin
    logic [3:0] p;
    ev_t e;
    p = {bus.err_timeout, bus.err_select, bus.err_pattern, bus.frame_valid};
    for (int k = 0; k < 4; k++) if (p[k]) begin
      if (q.size() == 0) check("unexpected_pulse_kind", k, 32'hFF);
      else begin
        e = q.pop_front();
        check("event_kind", k, e.kind);
        check("event_cycle", cyc, e.at);
        if (k == 0) begin
          check("frame_value", bus.digit_value, e.val);
          last_frame = cyc;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.dig_n = '1;
    bus.seg_n = '1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_digit_value", bus.digit_value, 0);
    check("rst_frame_valid", bus.frame_valid, 0);
    check("rst_err_pattern", bus.err_pattern, 0);
    check("rst_err_select", bus.err_select, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    reset = 1'b1;
    gap(5);

    scan(0, SEG_1, LONG);
    scan(1, SEG_2, LONG);
    scan(2, SEG_3, LONG);
    expect_ev(0, 16'h4321, cyc + LAT);
    scan(3, SEG_4, LONG);
    drain("frame_4321", 400);
    check("value_held_4321", bus.digit_value, 16'h4321);

    slot(0, SEG_5, 40);
    slot(0, SEG_8, 5);
    slot(0, SEG_5, 40);
    gap(30);
    scan(1, SEG_6, 40);
    scan(2, SEG_7, 40);
    expect_ev(0, 16'h8765, cyc + LAT);
    scan(3, SEG_8, 40);
    drain("frame_glitch", 400);

    scan(0, SEG_1, 40);
    scan(1, SEG_2, 40);
    expect_ev(1, 0, cyc + LAT);
    scan(2, 7'h49, 40);
    drain("err_pattern", 400);
    scan(3, SEG_3, 40);
    repeat (30) @(posedge clock);
    #1;
    check("no_frame_value", bus.digit_value, 16'h8765);
    expect_ev(0, 16'h3921, cyc + LAT);
    scan(2, SEG_9, 40);
    drain("frame_rescan", 400);

    expect_ev(2, 0, cyc + LAT);
    bus.dig_n = 4'b1100;
    bus.seg_n = ~SEG_1;
    repeat (20) @(posedge clock);
    #1;
    gap(30);
    drain("err_select", 400);
    scan(2, SEG_4, 40);
    scan(3, SEG_4, 40);
    scan(0, SEG_1, 40);
    expect_ev(0, 16'h4421, cyc + LAT);
    scan(1, SEG_2, 40);
    drain("frame_after_select", 400);

    scan(0, SEG_1, 40);
    scan(1, SEG_2, 40);
    scan(2, SEG_3, 40);
    reset = 1'b0;
    #1;
    check("async_reset_value", bus.digit_value, 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    gap(5);
    scan(3, SEG_9, 40);
    scan(0, SEG_0, 40);
    scan(1, SEG_0, 40);
    expect_ev(0, 16'h9500, cyc + LAT);
    scan(2, SEG_5, 40);
    drain("frame_after_reset", 400);

`ifdef SEG_SCAN_TIMEOUT_EN
    expect_ev(3, 0, last_frame + TO);
    scan(0, SEG_7, 40);
    drain("err_timeout", 1200);
    check("timeout_keeps_value", bus.digit_value, 16'h9500);
    scan(1, SEG_1, 40);
    scan(2, SEG_1, 40);
    scan(3, SEG_1, 40);
    repeat (30) @(posedge clock);
    #1;
    check("timeout_cleared_seen", bus.digit_value, 16'h9500);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
